// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver; 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Ports:
//   clk_i        - single clock, all state updates on the rising edge
//   reset_i      - synchronous, active-low reset
//   rx           - asynchronous serial line, idles high
//   data_o       - received byte, stable while valid_o is high
//   valid_o      - data_o holds an unconsumed byte
//   ready_i      - consumer takes data_o when valid_o && ready_i
//   frame_err_o  - one-cycle pulse on a low stop bit
//   overrun_o    - one-cycle pulse when a completed byte is dropped
//   parity_err_o - one-cycle pulse on an even-parity mismatch (constant 0 without UART_RX_PARITY_EN)
module uart_rx #(
    parameter int ClksPerBit = 868
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);
    localparam int CW = $clog2(ClksPerBit);
    localparam logic [CW-1:0] FULL = CW'(ClksPerBit - 1);
    localparam logic [CW-1:0] HALF = CW'(ClksPerBit / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    state_t        state, state_n;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          deliver, frame_bad;

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n, par_fail;
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_n     = bit_idx;
        shift_n   = shift;
        deliver   = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        par_fail  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n   = '0;
                bit_n   = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_n = 1'b0;
`endif
                state_n = rx_sync ? IDLE : START;
            end
            // Mid-start sample: a line already back high was a glitch.
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    state_n = rx_sync ? IDLE : DATA;
                end
            end
            // Counter restarts at mid-start, so each FULL lands mid-bit.
            DATA: begin
                if (cnt == FULL) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync, shift[7:1]};
                    bit_n   = bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_n = PARITY;
`else
                    if (bit_idx == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: data ones plus parity bit must be even.
            PARITY: begin
                if (cnt == FULL) begin
                    cnt_n     = '0;
                    par_fail  = rx_sync ^ (^shift);
                    par_bad_n = par_fail;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL) begin
                    cnt_n     = '0;
                    frame_bad = !rx_sync;
`ifdef UART_RX_PARITY_EN
                    deliver   = rx_sync && !par_bad;
`else
                    deliver   = rx_sync;
`endif
                    state_n   = rx_sync ? IDLE : WAIT_HIGH;
                end
            end
            // Break: hold off start detection until the line is released.
            WAIT_HIGH: begin
                cnt_n   = '0;
                state_n = rx_sync ? IDLE : WAIT_HIGH;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_sync     <= rx_meta;
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_n;
            shift       <= shift_n;
            frame_err_o <= frame_bad;
            // A full holding register that is not being drained drops the new byte.
            overrun_o   <= deliver && valid_o && !ready_i;
            if (deliver && (!valid_o || ready_i)) begin
                data_o  <= shift;
                valid_o <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            par_bad      <= par_bad_n;
            parity_err_o <= par_fail;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame-level check of uart_rx against a byte/event model.
module tb_uart_rx;
    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       rx = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overrun_o, parity_err_o;

    int checks = 0, errors = 0;
    int n_ferr = 0, n_perr = 0, n_ovr = 0, n_vcyc = 0;
    int e_ferr = 0, e_perr = 0, e_ovr = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;

    uart_rx #(.ClksPerBit(C)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .rx(rx), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .frame_err_o(frame_err_o), .overrun_o(overrun_o), .parity_err_o(parity_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        n_ferr += int'(frame_err_o);
        n_perr += int'(parity_err_o);
        n_ovr  += int'(overrun_o);
        n_vcyc += int'(valid_o);
        if (valid_o && ready_i) got_q.push_back(data_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(C);
    endtask

    task automatic model_deliver(input logic [7:0] b);
        if (ready_i) exp_q.push_back(b);
        else if (m_valid) e_ovr++;
        else begin
            m_valid = 1'b1;
            m_data  = b;
        end
    endtask

    task automatic model_consume();
        if (m_valid) exp_q.push_back(m_data);
        m_valid = 1'b0;
    endtask

    // One frame: start, 8 data LSB first, optional parity, stop; rx is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        logic bad_par;
        bad_par = PAR_EN && ((^b) != p);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit(p);
        drive_bit(s);
        if (bad_par) e_perr++;
        if (!s) e_ferr++;
        else if (!bad_par) model_deliver(b);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ferr"}, n_ferr, e_ferr);
        check({tag, "_perr"}, n_perr, e_perr);
        check({tag, "_ovr"}, n_ovr, e_ovr);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int v0;
        logic [7:0] b;
        logic p, s, r;

        tick(3);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        check("rst_perr", parity_err_o, 0);
        reset_i = 1'b1;
        tick(5);

        v0 = n_vcyc;
        send_frame(8'hA5, ^8'hA5, 1'b1);
        rx = 1'b1;
        tick(8);
        check("a5_vcyc", n_vcyc - v0, 1);
        check_state("a5");

        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check("glitch_valid", valid_o, 0);
        check_state("glitch");
        send_frame(8'h5A, ^8'h5A, 1'b1);
        rx = 1'b1;
        tick(8);
        check_state("5a");

        send_frame(8'h3C, ^8'h3C, 1'b0);
        tick(40);
        check("brk_valid", valid_o, 0);
        check_state("brk");
        rx = 1'b1;
        tick(6);
        send_frame(8'h66, ^8'h66, 1'b1);
        rx = 1'b1;
        tick(8);
        check_state("after_brk");

        ready_i = 1'b0;
        send_frame(8'h11, ^8'h11, 1'b1);
        send_frame(8'h22, ^8'h22, 1'b1);
        rx = 1'b1;
        tick(8);
        check("ovr_valid", valid_o, 1);
        check("ovr_data", data_o, 8'h11);
        check_state("ovr");
        ready_i = 1'b1;
        model_consume();
        tick(3);
        check("ovr_drain_valid", valid_o, 0);
        check_state("ovr_drain");

        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b_bit(8'h7E, i));
        reset_i = 1'b0;
        rx = 1'b1;
        tick(1);
        reset_i = 1'b1;
        tick(10);
        send_frame(8'h7E, ^8'h7E, 1'b1);
        rx = 1'b1;
        tick(8);
        check_state("rst_mid");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b0, 1'b1);
        rx = 1'b1;
        tick(8);
        check("par_bad_valid", valid_o, 0);
        check_state("par_bad");
        send_frame(8'h01, 1'b1, 1'b1);
        rx = 1'b1;
        tick(8);
        check_state("par_good");
`endif

        for (int k = 0; k < 24; k++) begin
            r = ($urandom_range(0, 2) != 0);
            if (r && !ready_i) begin
                ready_i = 1'b1;
                model_consume();
            end else begin
                ready_i = r;
            end
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            p = (^b) ^ ($urandom_range(0, 3) == 0);
            send_frame(b, p, s);
            if (!s) tick($urandom_range(0, 40));
            rx = 1'b1;
            tick($urandom_range(4, 20));
            check_state($sformatf("rnd%0d", k));
        end

        ready_i = 1'b1;
        model_consume();
        tick(5);
        check_state("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic b_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
